// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_arith_pkg;

    // Default operand width in bits
    localparam int unsigned SUB_WIDTH_DEFAULT = 8;

    // Legal operand width range
    localparam int unsigned SUB_WIDTH_MIN = 2;
    localparam int unsigned SUB_WIDTH_MAX = 32;

    // Control FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

    // Bit-counter width: must be able to hold the value WIDTH itself
    function automatic int unsigned sub_cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: diff = a - b - bin, with borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    // Difference bit and borrow-out for one bit position
    always_comb begin
        diff = a ^ b ^ bin;
        bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b modulo 2^WIDTH one bit per clock,
// LSB first, then publishes diff/borrow (and optionally ovf) together.
// Optional feature: define SERIAL_SUB_OVF_EN to enable the signed
// overflow flag; otherwise ovf is tied low and no overflow logic exists.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             ovf
);

    localparam int unsigned CNT_W = sub_cnt_width(WIDTH);

    if ((WIDTH < SUB_WIDTH_MIN) || (WIDTH > SUB_WIDTH_MAX)) begin : g_width_check
        $error("serial_subtractor: WIDTH out of range");
    end

    sub_state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bin_q, bin_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic fs_diff;
    logic fs_bout;
    logic last_bit;
    logic accept;

    // Oldest result bit falls off the bottom of the shift register
    logic unused_res_lsb;
    assign unused_res_lsb = res_q[0];

    full_subtractor u_fs (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (bin_q),
        .diff (fs_diff),
        .bout (fs_bout)
    );

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = (state_q == IDLE) && start;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // FSM outputs: busy through SHIFT and DONE, done only in DONE
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            IDLE:    ;
            SHIFT:   busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state: operand load, serial shift, result publish
    always_comb begin
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        if (accept) begin
            a_sh_d = a;
            b_sh_d = b;
            res_d  = '0;
            cnt_d  = '0;
            bin_d  = 1'b0;
        end else if (state_q == SHIFT) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {fs_diff, res_q[WIDTH-1:1]};
            bin_d  = fs_bout;
            cnt_d  = cnt_q + CNT_W'(1);
            // Publish straight from the final bit so outputs change only once
            if (last_bit) begin
                diff_d   = {fs_diff, res_q[WIDTH-1:1]};
                borrow_d = fs_bout;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;

    // Operand sign bits are kept aside since the shift registers lose them
    always_comb begin
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end else if ((state_q == SHIFT) && last_bit) begin
            ovf_d = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
        end
    end

    // Overflow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
